// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM demultiplexer: FSM state encoding,
// default geometry and the slot-length helper.
// Optional build macro: TDM_DEMUX_PARITY_EN (one even-parity bit per slot).
package tdm_pkg;

    localparam int DEF_CHANNELS = 4;
    localparam int DEF_WIDTH    = 8;

    typedef logic [0:0] state_t;
    localparam state_t HUNT = 1'b0;
    localparam state_t RECV = 1'b1;

    // Serial bits per slot: data bits, plus the trailing parity bit when enabled.
    function automatic int slot_bits(input int width);
`ifdef TDM_DEMUX_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/tdm_slot_shift.sv
// Slot assembler: places each accepted serial bit (MSB first) into the slot
// word, counts bits within the slot and, when enabled, accumulates parity.
// o_data and o_last describe the slot including the bit currently offered,
// so the owner can store a completed slot on the same edge as its last bit.
// Optional build macro: TDM_DEMUX_PARITY_EN (adds o_par_ok).
module tdm_slot_shift
    import tdm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_shift,    // accept i_din this cycle
    input  logic             i_restart,  // i_din is bit 0 of a fresh slot
    input  logic             i_din,
    output logic             o_last,     // accepted bit completes the slot
    output logic [WIDTH-1:0] o_data      // slot data including the current bit
`ifdef TDM_DEMUX_PARITY_EN
    ,
    output logic             o_par_ok    // even parity holds over the full slot
`endif
);

    localparam int               SLOT_BITS = slot_bits(WIDTH);
    localparam int               CNT_W     = $clog2(SLOT_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(SLOT_BITS - 1);
    localparam logic [WIDTH-1:0] MSB_MASK  = WIDTH'(1) << (WIDTH - 1);

    logic [CNT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0] r_slot;
    logic [CNT_W-1:0] w_idx;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_merged;

    // A restart makes the current bit index 0 and forgets the partial slot.
    assign w_idx    = i_restart ? '0 : r_bit_cnt;
    assign w_base   = i_restart ? '0 : r_slot;
    // Data bit n lands at position WIDTH-1-n; the parity bit index shifts the
    // mask out entirely, leaving the data word untouched.
    assign w_mask   = MSB_MASK >> w_idx;
    assign w_merged = i_din ? (w_base | w_mask) : w_base;
    assign o_last   = (w_idx == LAST_IDX);
    assign o_data   = w_merged;

`ifdef TDM_DEMUX_PARITY_EN
    logic r_par;
    logic w_par;

    assign w_par    = (i_restart ? 1'b0 : r_par) ^ i_din;
    assign o_par_ok = ~w_par;

    // Parity accumulator, cleared at every slot boundary.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_par <= 1'b0;
        end else if (i_shift) begin
            r_par <= o_last ? 1'b0 : w_par;
        end
    end
`endif

    // Bit counter and slot word; both return to zero once a slot completes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bit_cnt <= '0;
            r_slot    <= '0;
        end else if (i_shift) begin
            if (o_last) begin
                r_bit_cnt <= '0;
                r_slot    <= '0;
            end else begin
                r_bit_cnt <= w_idx + CNT_W'(1);
                r_slot    <= w_merged;
            end
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer top: hunts for a frame sync, then distributes CHANNELS
// serial slots into per-channel registers with one-cycle update pulses.
// Optional build macro: TDM_DEMUX_PARITY_EN (per-slot even parity check).
//
// Input handshake: din_valid qualifies din and sync; a cycle with din_valid
// low is invisible to the block (no shift, no counter change, no pulses).
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int WIDTH    = DEF_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      din,
    input  logic                      din_valid,
    input  logic                      sync,
    output logic [CHANNELS*WIDTH-1:0] ch_data,
    output logic [CHANNELS-1:0]       ch_valid,
    output logic                      frame_done,
    output logic                      frame_err,
    output logic                      parity_err,
    output logic                      busy,
    output state_t                    dbg_state
);

    localparam int            CH_W    = $clog2(CHANNELS);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

    state_t                    r_state;
    logic [CH_W-1:0]           r_ch_cnt;
    logic [CHANNELS*WIDTH-1:0] r_ch_data;
    logic [CHANNELS-1:0]       r_ch_valid;
    logic                      r_frame_done;
    logic                      r_frame_err;

    logic                      w_restart;
    logic                      w_shift;
    logic                      w_last;
    logic [WIDTH-1:0]          w_data;
    logic [CH_W-1:0]           w_ch_idx;
    logic                      w_store;
    logic                      w_final;
    logic                      w_good;
    logic [CHANNELS-1:0]       w_onehot;

    // Any accepted sync restarts at channel 0 bit 0; in HUNT only a sync bit
    // is taken, everything else is dropped.
    assign w_restart = din_valid & sync;
    assign w_shift   = din_valid & ((r_state == RECV) | sync);
    assign w_ch_idx  = w_restart ? '0 : r_ch_cnt;
    assign w_store   = w_shift & w_last;
    assign w_final   = w_store & (w_ch_idx == LAST_CH);
    assign w_onehot  = CHANNELS'(1) << w_ch_idx;

    tdm_slot_shift #(
        .WIDTH(WIDTH)
    ) u_slot (
        .i_clk     (clock),
        .i_rst     (reset),
        .i_shift   (w_shift),
        .i_restart (w_restart),
        .i_din     (din),
        .o_last    (w_last),
        .o_data    (w_data)
`ifdef TDM_DEMUX_PARITY_EN
        ,
        .o_par_ok  (w_good)
`endif
    );

`ifdef TDM_DEMUX_PARITY_EN
    logic r_parity_err;

    // Parity failure replaces the channel update pulse for that slot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_store & ~w_good;
        end
    end

    assign parity_err = r_parity_err;
`else
    assign w_good     = 1'b1;
    assign parity_err = 1'b0;
`endif

    // Frame FSM and channel counter; the last slot of a frame returns to HUNT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= HUNT;
            r_ch_cnt <= '0;
        end else if (w_shift) begin
            if (w_final) begin
                r_state  <= HUNT;
                r_ch_cnt <= '0;
            end else if (w_store) begin
                r_state  <= RECV;
                r_ch_cnt <= w_ch_idx + CH_W'(1);
            end else begin
                r_state  <= RECV;
                r_ch_cnt <= w_ch_idx;
            end
        end
    end

    // Channel registers and single-cycle status pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ch_data    <= '0;
            r_ch_valid   <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_ch_valid   <= (w_store & w_good) ? w_onehot : '0;
            r_frame_done <= w_final;
            r_frame_err  <= w_restart & (r_state == RECV);
            if (w_store & w_good) begin
                r_ch_data[w_ch_idx*WIDTH +: WIDTH] <= w_data;
            end
        end
    end

    assign ch_data    = r_ch_data;
    assign ch_valid   = r_ch_valid;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state == RECV);
    assign dbg_state  = r_state;

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 Parameter CHANNELS, default 4: number of time slots per frame, 2..16.
REQ-002 Parameter WIDTH, default 8: data bits per slot, 1..16.
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 din  input  1  serial TDM data, MSB of each slot first.
REQ-006 din_valid  input  1  qualifies din and sync; when low, all counters and state hold.
REQ-007 sync  input  1  frame start marker, sampled only when din_valid=1.
REQ-008 ch_data  output  CHANNELS*WIDTH  channel registers; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 ch_valid  output  CHANNELS  one-hot, one-cycle pulse marking the channel register just updated.
REQ-010 frame_done  output  1  one-cycle pulse after the last slot of a frame is stored.
REQ-011 frame_err  output  1  one-cycle pulse when a frame is aborted by a mid-frame sync.
REQ-012 parity_err  output  1  one-cycle pulse on slot parity mismatch (tied 0 when parity is compiled out).
REQ-013 busy  output  1  high while in state RECV.

Function
REQ-014 FSM states HUNT and RECV; bit counter 0..SLOT_BITS-1 and channel counter 0..CHANNELS-1 (SLOT_BITS = WIDTH, or WIDTH+1 with parity).
REQ-015 HUNT: accepted bits with sync=0 are discarded; an accepted bit with sync=1 is bit 0 of channel 0 -> RECV.
REQ-016 RECV: each accepted bit shifts into the slot register; the bit counter increments; at SLOT_BITS-1 it wraps to 0 and the channel counter increments.
REQ-017 On the final bit of a slot, ch_data for that channel and ch_valid[channel] update in the next cycle (latency 1 cycle after the last accepted bit); other channels hold.
REQ-018 On the final bit of channel CHANNELS-1, frame_done pulses with that channel's ch_valid, and the FSM returns to HUNT.
REQ-019 sync=1 on an accepted bit in RECV (including the final bit of the frame) pulses frame_err, discards the partial slot, and restarts with that bit as channel 0 bit 0; the FSM stays in RECV.
REQ-020 Previously stored channel registers are never cleared by an aborted frame.
REQ-021 din_valid=0 mid-slot: no shift, no counter change, no output pulses.
REQ-022 A sync arriving on the first accepted bit after frame_done starts a new frame with no error.

Reset
REQ-023 reset forces HUNT, clears counters and the shift register, ch_data=0, and ch_valid, frame_done, frame_err, parity_err and busy to 0.
REQ-024 Reset mid-frame discards the partial frame; the next frame requires a fresh sync.

Configuration
REQ-025 Macro TDM_DEMUX_PARITY_EN defined: each slot carries WIDTH data bits followed by one even-parity bit (XOR of all WIDTH+1 bits = 0).
REQ-026 With TDM_DEMUX_PARITY_EN, a mismatch pulses parity_err in place of ch_valid; that channel register holds its old value; frame_done still pulses on the last slot.
REQ-027 Without TDM_DEMUX_PARITY_EN: SLOT_BITS=WIDTH, no parity logic, parity_err constantly 0.

Structure
REQ-028 Package tdm_pkg holds the FSM state typedef (HUNT, RECV) and the default CHANNELS and WIDTH constants.
REQ-029 Sub-module tdm_slot_shift (shift register, bit counter, optional parity accumulator) shall be instantiated once; the top holds the FSM, channel counter and output registers.

Verification (CHANNELS=4, WIDTH=8)
REQ-030 Sync + slots 0xA5, 0x3C, 0xFF, 0x01 continuous -> ch_data=0x01FF3CA5; ch_valid pulses 0001, 0010, 0100, 1000, each 1 cycle after the slot's 8th bit; frame_done with 1000.
REQ-031 Same frame with din_valid low for 3 cycles inside slot 1 -> identical ch_data; ch_valid pulses delayed by 3 cycles only.
REQ-032 Sync again at bit 4 of slot 2 -> frame_err pulse; ch0 and ch1 keep their values; new frame 0x11, 0x22, 0x33, 0x44 -> ch_data=0x44332211.
REQ-033 Bits before the first sync (16 random bits) -> no outputs change, busy=0.
REQ-034 reset asserted at bit 3 of slot 1, then a full frame -> all outputs 0 during reset, then the correct frame is stored.
REQ-035 With TDM_DEMUX_PARITY_EN, slot 2 = 0x0F with parity bit 1 -> parity_err pulse, ch2 unchanged, frame_done still pulses.
